// File: rtl/des_batch_sequencer.sv
// -----------------------------------------------------------------------------
// des_batch_sequencer
//
// Walks a 3DES core across a contiguous batch of 64-bit blocks held in a
// single-port synchronous RAM. For every block it resets the core, reads
// the source block, pulses core_start, waits for core_done and writes the
// result to the destination region. The host only has to issue one start
// per batch.
//
// Build option:
//   DES_CBC_EN  defined   -> CBC chaining (encrypt direction). An extra iv
//                            input is latched at start. The core is fed
//                            mem_rdata ^ chain, and chain takes core_dout on
//                            every core_done.
//               undefined -> ECB. The core is fed mem_rdata and there is no
//                            iv port.
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   asynchronous active-low reset
//   start        in   batch request, sampled only while idle
//   num_blocks   in   number of blocks in the batch, latched at start
//   src_base     in   first source address, latched at start
//   dst_base     in   first destination address, latched at start
//   iv           in   CBC initial vector (only when DES_CBC_EN is defined)
//   busy         out  high from an accepted start until done
//   done         out  one-cycle pulse at the end of the batch
//   error        out  sticky core timeout flag, cleared by the next start
//   blocks_done  out  number of blocks written so far
//   mem_addr     out  RAM address
//   mem_we       out  RAM write enable
//   mem_wdata    out  RAM write data
//   mem_rdata    in   RAM read data, one cycle after the address
//   core_rst_n   out  core reset, active-low
//   core_start   out  one-cycle start pulse to the core
//   core_din     out  block for the core, valid with core_start
//   core_dout    in   core result, valid with core_done
//   core_done    in   one-cycle completion pulse from the core
// -----------------------------------------------------------------------------
module des_batch_sequencer #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 64,
  parameter int CNT_W   = 8,
  parameter int RST_CYC = 2,
  parameter int TMO_CYC = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_blocks,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
`ifdef DES_CBC_EN
  input  logic [DATA_W-1:0] iv,
`endif
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [CNT_W-1:0]  blocks_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              core_rst_n,
  output logic              core_start,
  output logic [DATA_W-1:0] core_din,
  input  logic [DATA_W-1:0] core_dout,
  input  logic              core_done
);

  typedef enum logic [3:0] {
    S_IDLE,   // waiting for start
    S_CRST,   // core held in reset for RST_CYC cycles
    S_RD,     // source address presented to the RAM
    S_RWAIT,  // read data arrives and is captured into core_din
    S_KICK,   // core_start high for one cycle
    S_RUN,    // waiting for core_done or a timeout
    S_WR,     // result written to the destination
    S_NEXT,   // advance the block index
    S_FIN     // end of batch, done pulse follows
  } state_t;

  // Counters are sized so the compare value always fits. A one-bit minimum
  // keeps RST_CYC=1 and TMO_CYC<=1 legal.
  localparam int RC_W  = (RST_CYC < 2) ? 1 : $clog2(RST_CYC);
  localparam int TMO_W = (TMO_CYC < 2) ? 1 : $clog2(TMO_CYC);

  state_t            state;
  logic [CNT_W-1:0]  idx;
  logic [CNT_W-1:0]  n_lat;
  logic [ADDR_W-1:0] src_lat;
  logic [ADDR_W-1:0] dst_lat;
  logic [RC_W-1:0]   rst_cnt;
  logic [TMO_W-1:0]  tmo_cnt;
`ifdef DES_CBC_EN
  logic [DATA_W-1:0] chain;
`endif

  // Base+index wraps modulo 2**ADDR_W because the sum is truncated to ADDR_W.
  logic [ADDR_W-1:0] src_addr;
  logic [ADDR_W-1:0] dst_addr;
  assign src_addr = src_lat + ADDR_W'(idx);
  assign dst_addr = dst_lat + ADDR_W'(idx);

  // NOTE: every register here updates with non-blocking assignments, so the
  // whole FSM sees the previous cycle's values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      blocks_done <= '0;
      mem_addr    <= '0;
      mem_we      <= 1'b0;
      mem_wdata   <= '0;
      core_rst_n  <= 1'b0;
      core_start  <= 1'b0;
      core_din    <= '0;
      idx         <= '0;
      n_lat       <= '0;
      src_lat     <= '0;
      dst_lat     <= '0;
      rst_cnt     <= '0;
      tmo_cnt     <= '0;
`ifdef DES_CBC_EN
      chain       <= '0;
`endif
    end else begin
      done <= 1'b0;

      unique case (state)
        S_IDLE: begin
          core_rst_n <= 1'b1;
          if (start) begin
            busy        <= 1'b1;
            error       <= 1'b0;
            blocks_done <= '0;
            idx         <= '0;
            n_lat       <= num_blocks;
            src_lat     <= src_base;
            dst_lat     <= dst_base;
            rst_cnt     <= '0;
`ifdef DES_CBC_EN
            chain       <= iv;
`endif
            if (num_blocks == '0) begin
              // An empty batch just spends one busy cycle and then pulses done.
              state <= S_FIN;
            end else begin
              core_rst_n <= 1'b0;
              state      <= S_CRST;
            end
          end
        end

        S_CRST: begin
          if (rst_cnt == RC_W'(RST_CYC - 1)) begin
            core_rst_n <= 1'b1;
            mem_addr   <= src_addr;
            state      <= S_RD;
          end else begin
            rst_cnt <= rst_cnt + 1'b1;
          end
        end

        S_RD: begin
          // The RAM registers the address on this edge, so data is valid in RWAIT.
          state <= S_RWAIT;
        end

        S_RWAIT: begin
`ifdef DES_CBC_EN
          core_din <= mem_rdata ^ chain;
`else
          core_din <= mem_rdata;
`endif
          core_start <= 1'b1;
          state      <= S_KICK;
        end

        S_KICK: begin
          core_start <= 1'b0;
          tmo_cnt    <= '0;
          state      <= S_RUN;
        end

        S_RUN: begin
          // A core_done on the cycle the timeout expires still counts as
          // success, so it is tested first.
          if (core_done) begin
            mem_wdata <= core_dout;
            mem_addr  <= dst_addr;
            mem_we    <= 1'b1;
`ifdef DES_CBC_EN
            chain     <= core_dout;
`endif
            state     <= S_WR;
          end else if (TMO_CYC != 0 && tmo_cnt == TMO_W'(TMO_CYC - 1)) begin
            error <= 1'b1;
            state <= S_FIN;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end

        S_WR: begin
          mem_we <= 1'b0;
          state  <= S_NEXT;
        end

        S_NEXT: begin
          idx         <= idx + 1'b1;
          blocks_done <= blocks_done + 1'b1;
          if (idx + 1'b1 == n_lat) begin
            state <= S_FIN;
          end else begin
            core_rst_n <= 1'b0;
            rst_cnt    <= '0;
            state      <= S_CRST;
          end
        end

        S_FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_des_batch_sequencer.sv
module tb_des_batch_sequencer;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 64;
  localparam int CNT_W  = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [CNT_W-1:0]  num_blocks;
  logic [ADDR_W-1:0] src_base;
  logic [ADDR_W-1:0] dst_base;
  logic [DATA_W-1:0] iv;
  logic              busy;
  logic              done;
  logic              error;
  logic [CNT_W-1:0]  blocks_done;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              core_rst_n;
  logic              core_start;
  logic [DATA_W-1:0] core_din;
  logic [DATA_W-1:0] core_dout;
  logic              core_done;

  always #5 clk = ~clk;

  des_batch_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .num_blocks (num_blocks),
    .src_base   (src_base),
    .dst_base   (dst_base),
`ifdef DES_CBC_EN
    .iv         (iv),
`endif
    .busy       (busy),
    .done       (done),
    .error      (error),
    .blocks_done(blocks_done),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .core_rst_n (core_rst_n),
    .core_start (core_start),
    .core_din   (core_din),
    .core_dout  (core_dout),
    .core_done  (core_done)
  );

  // Single-port sync RAM with a bench-side load port used while the DUT idles.
  logic [DATA_W-1:0] ram [0:255];
  logic              ld_en;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;

  always @(posedge clk) begin
    if (ld_en)       ram[ld_addr]  <= ld_data;
    else if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  // Stub core: dout = ~din, core_done 16 cycles after core_start.
  logic stub_hang;
  int   stub_cnt;

  always @(posedge clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      stub_cnt  <= 0;
      core_done <= 1'b0;
      core_dout <= '0;
    end else begin
      core_done <= 1'b0;
      if (core_start && !stub_hang) begin
        stub_cnt  <= 15;
        core_dout <= ~core_din;
      end else if (stub_cnt != 0) begin
        stub_cnt <= stub_cnt - 1;
        if (stub_cnt == 1) core_done <= 1'b1;
      end
    end
  end

  // Activity monitor, sampled on the falling edge.
  int                cyc      = 0;
  int                low_run  = 0;
  int                last_low = 0;
  int                n_wr     = 0;
  int                n_st     = 0;
  int                n_done   = 0;
  int                done_cyc = 0;
  int                wr_at_done = 0;
  logic [ADDR_W-1:0] wr_addr [0:63];
  logic [DATA_W-1:0] wr_data [0:63];
  int                wr_cyc  [0:63];
  logic [DATA_W-1:0] st_din  [0:63];
  int                st_low  [0:63];
  int                st_cyc  [0:63];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (!core_rst_n) begin
      low_run <= low_run + 1;
    end else if (low_run != 0) begin
      last_low <= low_run;
      low_run  <= 0;
    end
    if (mem_we && n_wr < 64) begin
      wr_addr[n_wr] <= mem_addr;
      wr_data[n_wr] <= mem_wdata;
      wr_cyc[n_wr]  <= cyc;
      n_wr          <= n_wr + 1;
    end
    if (core_start && n_st < 64) begin
      st_din[n_st] <= core_din;
      st_low[n_st] <= last_low;
      st_cyc[n_st] <= cyc;
      n_st         <= n_st + 1;
    end
    if (done) begin
      n_done     <= n_done + 1;
      done_cyc   <= cyc;
      wr_at_done <= n_wr;
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic load(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    @(negedge clk);
    ld_en   = 1'b1;
    ld_addr = a;
    ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  // Pulses start for one cycle; returns at the falling edge after the accept edge.
  task automatic kick(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] d,
                      input logic [CNT_W-1:0] n);
    @(negedge clk);
    src_base   = s;
    dst_base   = d;
    num_blocks = n;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int i;
    i = 0;
    while (done !== 1'b1 && i < budget) begin
      @(negedge clk);
      i++;
    end
    check({tag, "_done_seen"}, 64'(i < budget), 64'd1);
    #1;
  endtask

  logic [DATA_W-1:0] t2_src [4];
  logic [DATA_W-1:0] t2_exp [4];
  logic [DATA_W-1:0] t5_src [4];
  logic [DATA_W-1:0] t5_exp [4];
  logic [ADDR_W-1:0] t5_adr [4];

  initial begin
    int wb, sb, db;

    t2_src = '{64'h0000000000000000, 64'hFFFFFFFFFFFFFFFF,
               64'h0123456789ABCDEF, 64'h8000000000000001};
    t2_exp = '{64'hFFFFFFFFFFFFFFFF, 64'h0000000000000000,
               64'hFEDCBA9876543210, 64'h7FFFFFFFFFFFFFFE};
    t5_adr = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    t5_src = '{64'hDEADBEEF00000000, 64'h00000000CAFEF00D,
               64'h5555AAAA5555AAAA, 64'h0000000000000001};
    t5_exp = '{64'h21524110FFFFFFFF, 64'hFFFFFFFF35010FF2,
               64'hAAAA5555AAAA5555, 64'hFFFFFFFFFFFFFFFE};

    reset      = 1'b0;
    start      = 1'b0;
    num_blocks = '0;
    src_base   = '0;
    dst_base   = '0;
    iv         = '0;
    ld_en      = 1'b0;
    ld_addr    = '0;
    ld_data    = '0;
    stub_hang  = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_busy",       64'(busy),        64'd0);
    check("rst_done",       64'(done),        64'd0);
    check("rst_error",      64'(error),       64'd0);
    check("rst_core_rst_n", 64'(core_rst_n),  64'd0);
    check("rst_mem_we",     64'(mem_we),      64'd0);
    check("rst_mem_addr",   64'(mem_addr),    64'd0);
    check("rst_mem_wdata",  mem_wdata,        64'd0);
    check("rst_core_din",   core_din,         64'd0);
    check("rst_blocks",     64'(blocks_done), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    check("idle_core_rst_n", 64'(core_rst_n), 64'd1);

    // 1: single block, latency from core_start to write
    load(8'h00, 64'h123456ABCD132536);
    wb = n_wr; sb = n_st; db = n_done;
    kick(8'h00, 8'h40, 8'd1);
    wait_done("t1", 200);
    @(negedge clk); #1;
    check("t1_mem40",   ram[8'h40],       64'hEDCBA95432ECDAC9);
    check("t1_writes",  64'(n_wr - wb),   64'd1);
    check("t1_waddr",   64'(wr_addr[wb]), 64'h40);
    check("t1_dones",   64'(n_done - db), 64'd1);
    check("t1_blocks",  64'(blocks_done), 64'd1);
    check("t1_error",   64'(error),       64'd0);
    check("t1_rstlow",  64'(st_low[sb]),  64'd2);
    check("t1_latency", 64'(wr_cyc[wb] - st_cyc[sb]), 64'd17);

    // 2: four blocks, in-order writes, core reset before every start
    for (int i = 0; i < 4; i++) load(8'h10 + 8'(i), t2_src[i]);
    wb = n_wr; sb = n_st; db = n_done;
    kick(8'h10, 8'h20, 8'd4);
    wait_done("t2", 400);
    check("t2_writes_at_done", 64'(wr_at_done - wb), 64'd4);
    check("t2_starts",  64'(n_st - sb),   64'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t2_waddr%0d", i), 64'(wr_addr[wb+i]), 64'(8'h20 + 8'(i)));
      check($sformatf("t2_wdata%0d", i), wr_data[wb+i], t2_exp[i]);
      check($sformatf("t2_rstlow%0d", i), 64'(st_low[sb+i]), 64'd2);
    end
    check("t2_blocks",  64'(blocks_done), 64'd4);

    // 3: empty batch
    wb = n_wr; sb = n_st; db = n_done;
    kick(8'h00, 8'h00, 8'd0);
    check("t3_busy1",   64'(busy), 64'd1);
    check("t3_nodone1", 64'(done), 64'd0);
    @(negedge clk);
    check("t3_done",    64'(done), 64'd1);
    check("t3_busy0",   64'(busy), 64'd0);
    @(negedge clk); #1;
    check("t3_writes",  64'(n_wr - wb), 64'd0);
    check("t3_starts",  64'(n_st - sb), 64'd0);
    check("t3_dones",   64'(n_done - db), 64'd1);

    // 4: core never finishes, 255-cycle timeout, next start clears error
    stub_hang = 1'b1;
    wb = n_wr; sb = n_st;
    kick(8'h00, 8'h50, 8'd1);
    wait_done("t4", 600);
    check("t4_error",   64'(error), 64'd1);
    check("t4_writes",  64'(n_wr - wb), 64'd0);
    check("t4_timeout", 64'(done_cyc - st_cyc[sb]), 64'd257);
    stub_hang = 1'b0;
    kick(8'h00, 8'h50, 8'd1);
    check("t4_err_clear", 64'(error), 64'd0);
    wait_done("t4b", 200);
    check("t4b_error",  64'(error), 64'd0);
    check("t4b_mem50",  ram[8'h50], 64'hEDCBA95432ECDAC9);

    // 5: reset during RUN of block 2, then a wrapped full batch
    sb = n_st;
    kick(8'h10, 8'h30, 8'd4);
    begin
      int i;
      i = 0;
      while (n_st < sb + 2 && i < 400) begin
        @(negedge clk);
        i++;
      end
      check("t5_reach_blk2", 64'(i < 400), 64'd1);
    end
    repeat (5) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("t5_busy",       64'(busy),        64'd0);
    check("t5_core_rst_n", 64'(core_rst_n),  64'd0);
    check("t5_core_start", 64'(core_start),  64'd0);
    check("t5_mem_we",     64'(mem_we),      64'd0);
    check("t5_mem_addr",   64'(mem_addr),    64'd0);
    check("t5_blocks",     64'(blocks_done), 64'd0);
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) load(t5_adr[i], t5_src[i]);
    wb = n_wr;
    kick(8'hFE, 8'h80, 8'd4);
    wait_done("t5", 400);
    check("t5_writes", 64'(wr_at_done - wb), 64'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t5_waddr%0d", i), 64'(wr_addr[wb+i]), 64'(8'h80 + 8'(i)));
      check($sformatf("t5_wdata%0d", i), wr_data[wb+i], t5_exp[i]);
    end
    check("t5_blocks_end", 64'(blocks_done), 64'd4);

`ifdef DES_CBC_EN
    // 6: CBC chaining on zero plaintext
    load(8'h00, 64'h0);
    load(8'h01, 64'h0);
    iv = 64'h0F0F0F0F0F0F0F0F;
    sb = n_st;
    kick(8'h00, 8'h60, 8'd2);
    wait_done("t6", 400);
    check("t6_din0", st_din[sb],   64'h0F0F0F0F0F0F0F0F);
    check("t6_din1", st_din[sb+1], 64'hF0F0F0F0F0F0F0F0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
